// File: rtl/hazard_scoreboard_if.sv
// Hazard-unit bundle: decode/execute/memory/writeback register info in,
// stall/flush/forward controls out.
interface hazard_scoreboard_if #(
    parameter int REG_BITS = 5
);
    logic [REG_BITS-1:0] rs_id_d;
    logic [REG_BITS-1:0] rt_id_d;
    logic                branch_d;
    logic                syscall_d;
    logic                mf_op_in_d;
    logic                div_op_d;
    logic [REG_BITS-1:0] rs_id_e;
    logic [REG_BITS-1:0] rt_id_e;
    logic [REG_BITS-1:0] write_reg_e;
    logic                reg_write_e;
    logic                mem_to_reg_e;
    logic [REG_BITS-1:0] rd_id_m;
    logic                reg_write_m;
    logic                mem_to_reg_m;
    logic [REG_BITS-1:0] rd_id_w;
    logic                reg_write_w;
    logic                stall_f;
    logic                stall_d;
    logic                flush_e;
    logic                forward_rs_d;
    logic                forward_rt_d;
    logic [1:0]          forward_rs_e;
    logic [1:0]          forward_rt_e;
    logic                hilo_busy;
    logic                stall_timeout;

    modport master (
        output rs_id_d, rt_id_d, branch_d, syscall_d, mf_op_in_d, div_op_d,
               rs_id_e, rt_id_e, write_reg_e, reg_write_e, mem_to_reg_e,
               rd_id_m, reg_write_m, mem_to_reg_m, rd_id_w, reg_write_w,
        input  stall_f, stall_d, flush_e, forward_rs_d, forward_rt_d,
               forward_rs_e, forward_rt_e, hilo_busy, stall_timeout
    );

    modport slave (
        input  rs_id_d, rt_id_d, branch_d, syscall_d, mf_op_in_d, div_op_d,
               rs_id_e, rt_id_e, write_reg_e, reg_write_e, mem_to_reg_e,
               rd_id_m, reg_write_m, mem_to_reg_m, rd_id_w, reg_write_w,
        output stall_f, stall_d, flush_e, forward_rs_d, forward_rt_d,
               forward_rs_e, forward_rt_e, hilo_busy, stall_timeout
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding, load/branch/syscall/
// HI-LO stalls, iterative-divider busy tracking and a sticky stall watchdog.
module hazard_scoreboard #(
    parameter int REG_BITS    = 5,
    parameter int DIV_LATENCY = 8,
    parameter int MAX_STALL   = 64,
    parameter int SYS_REG_A   = 2,
    parameter int SYS_REG_B   = 4
) (
    input logic              clock,
    input logic              reset,
    hazard_scoreboard_if.slave hz
);
    localparam int DIV_W = $clog2(DIV_LATENCY + 1);
    localparam int STL_W = $clog2(MAX_STALL + 1);
    localparam logic [REG_BITS-1:0] SYS_A = REG_BITS'(SYS_REG_A);
    localparam logic [REG_BITS-1:0] SYS_B = REG_BITS'(SYS_REG_B);

    // Register 0 is hard-wired zero, so it never produces a hazard.
    function automatic logic writes(input logic we, input logic [REG_BITS-1:0] dest,
                                    input logic [REG_BITS-1:0] src);
        return we && (dest != '0) && (dest == src);
    endfunction

    function automatic logic writes_sys(input logic we, input logic [REG_BITS-1:0] dest);
        return writes(we, dest, SYS_A) || writes(we, dest, SYS_B);
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic [STL_W-1:0] stall_cnt;
    logic             timeout;
    logic             busy;
    logic             lw_stall, branch_stall, syscall_stall, mf_stall, div_struct_stall;
    logic             stall;
    logic             div_issue;

    always_comb begin
        hz.forward_rs_e = 2'b00;
        if (writes(hz.reg_write_m, hz.rd_id_m, hz.rs_id_e))
            hz.forward_rs_e = 2'b10;
        else if (writes(hz.reg_write_w, hz.rd_id_w, hz.rs_id_e))
            hz.forward_rs_e = 2'b01;

        hz.forward_rt_e = 2'b00;
        if (writes(hz.reg_write_m, hz.rd_id_m, hz.rt_id_e))
            hz.forward_rt_e = 2'b10;
        else if (writes(hz.reg_write_w, hz.rd_id_w, hz.rt_id_e))
            hz.forward_rt_e = 2'b01;
    end

    assign hz.forward_rs_d = hz.branch_d && !hz.mem_to_reg_m &&
                             writes(hz.reg_write_m, hz.rd_id_m, hz.rs_id_d);
    assign hz.forward_rt_d = hz.branch_d && !hz.mem_to_reg_m &&
                             writes(hz.reg_write_m, hz.rd_id_m, hz.rt_id_d);

    assign busy = (div_cnt != '0);

    always_comb begin
        lw_stall = hz.mem_to_reg_e &&
                   (writes(hz.reg_write_e, hz.write_reg_e, hz.rs_id_d) ||
                    writes(hz.reg_write_e, hz.write_reg_e, hz.rt_id_d));

        // A branch resolves in decode: an E result is too late, and an M load
        // has no data yet, so both force a stall rather than a forward.
        branch_stall = hz.branch_d &&
                       (writes(hz.reg_write_e, hz.write_reg_e, hz.rs_id_d) ||
                        writes(hz.reg_write_e, hz.write_reg_e, hz.rt_id_d) ||
                        (hz.mem_to_reg_m &&
                         (writes(hz.reg_write_m, hz.rd_id_m, hz.rs_id_d) ||
                          writes(hz.reg_write_m, hz.rd_id_m, hz.rt_id_d))));

        syscall_stall = hz.syscall_d &&
                        (writes_sys(hz.reg_write_e, hz.write_reg_e) ||
                         writes_sys(hz.reg_write_m, hz.rd_id_m) ||
                         writes_sys(hz.reg_write_w, hz.rd_id_w));

        mf_stall         = hz.mf_op_in_d && busy;
        div_struct_stall = hz.div_op_d && busy;

        stall = !reset && (lw_stall || branch_stall || syscall_stall ||
                           mf_stall || div_struct_stall);
    end

    assign hz.stall_f       = stall;
    assign hz.stall_d       = stall;
    assign hz.flush_e       = stall;
    assign hz.hilo_busy     = busy;
    assign hz.stall_timeout = timeout;

    assign div_issue = hz.div_op_d && !stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_issue) begin
            div_cnt <= DIV_W'(DIV_LATENCY);
        end else if (busy) begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    // Watchdog: timeout samples the saturated count, so it rises one edge later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            if (!stall)
                stall_cnt <= '0;
            else if (stall_cnt != STL_W'(MAX_STALL))
                stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == STL_W'(MAX_STALL))
                timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;
    logic clock;
    logic reset;
    int   total;
    int   bad;
    int   n;

    hazard_scoreboard_if #(.REG_BITS(5)) hz ();

    hazard_scoreboard #(
        .REG_BITS(5), .DIV_LATENCY(8), .MAX_STALL(64), .SYS_REG_A(2), .SYS_REG_B(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .hz(hz.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        hz.rs_id_d = '0; hz.rt_id_d = '0; hz.branch_d = 0; hz.syscall_d = 0;
        hz.mf_op_in_d = 0; hz.div_op_d = 0; hz.rs_id_e = '0; hz.rt_id_e = '0;
        hz.write_reg_e = '0; hz.reg_write_e = 0; hz.mem_to_reg_e = 0;
        hz.rd_id_m = '0; hz.reg_write_m = 0; hz.mem_to_reg_m = 0;
        hz.rd_id_w = '0; hz.reg_write_w = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_lw_hazard();
        hz.write_reg_e = 5'd8; hz.reg_write_e = 1; hz.mem_to_reg_e = 1; hz.rt_id_d = 5'd8;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr();
        reset = 1'b1;
        // Hazard present during reset: stalls forced low, forwards still live.
        set_lw_hazard();
        hz.rd_id_m = 5'd5; hz.reg_write_m = 1; hz.rs_id_e = 5'd5;
        #12;
        check("rst_stall_f", hz.stall_f, 0);
        check("rst_flush_e", hz.flush_e, 0);
        check("rst_busy", hz.hilo_busy, 0);
        check("rst_timeout", hz.stall_timeout, 0);
        check("rst_fwd_live", hz.forward_rs_e, 2'b10);
        clr();
        reset = 1'b0;
        step();

        // Forwarding priority and reg 0
        hz.rd_id_m = 5'd5; hz.reg_write_m = 1; hz.rd_id_w = 5'd5; hz.reg_write_w = 1;
        hz.rs_id_e = 5'd5; hz.rt_id_e = 5'd5;
        #1;
        check("fwd_rs_m", hz.forward_rs_e, 2'b10);
        check("fwd_rt_m", hz.forward_rt_e, 2'b10);
        hz.reg_write_m = 0;
        #1;
        check("fwd_rs_w", hz.forward_rs_e, 2'b01);
        hz.rs_id_e = 5'd0; hz.rd_id_w = 5'd0;
        #1;
        check("fwd_rs_r0", hz.forward_rs_e, 2'b00);
        check("fwd_rt_none", hz.forward_rt_e, 2'b00);
        clr();
        step();

        // Load-use stall for one cycle
        set_lw_hazard();
        #1;
        check("lw_stall_f", hz.stall_f, 1);
        check("lw_stall_d", hz.stall_d, 1);
        check("lw_flush_e", hz.flush_e, 1);
        step();
        clr();
        #1;
        check("lw_clear", hz.stall_f, 0);
        hz.write_reg_e = 5'd0; hz.reg_write_e = 1; hz.mem_to_reg_e = 1; hz.rt_id_d = 5'd0;
        #1;
        check("lw_r0", hz.stall_f, 0);
        clr();
        step();

        // Divider issue then mfhi waits exactly DIV_LATENCY cycles
        hz.div_op_d = 1;
        #1;
        check("div_issue_nostall", hz.stall_f, 0);
        step();
        hz.div_op_d = 0; hz.mf_op_in_d = 1;
        #1;
        check("div_busy", hz.hilo_busy, 1);
        n = 0;
        while (hz.stall_f && n < 20) begin
            n++;
            step();
        end
        check("mf_stall_len", n, 8);
        check("div_busy_drop", hz.hilo_busy, 0);
        // Second div while busy is held off structurally
        hz.mf_op_in_d = 0; hz.div_op_d = 1;
        step();
        #1;
        check("div_struct", hz.stall_f, 1);
        clr();
        for (int i = 0; i < 8; i++) step();
        check("div_idle", hz.hilo_busy, 0);

        // Decode-stage branch forwarding
        hz.branch_d = 1; hz.rs_id_d = 5'd9; hz.rd_id_m = 5'd9; hz.reg_write_m = 1;
        #1;
        check("br_fwd_rs", hz.forward_rs_d, 1);
        check("br_fwd_rt", hz.forward_rt_d, 0);
        check("br_nostall", hz.stall_f, 0);
        hz.mem_to_reg_m = 1;
        #1;
        check("br_load_stall", hz.stall_f, 1);
        check("br_load_nofwd", hz.forward_rs_d, 0);
        hz.mem_to_reg_m = 0; hz.rd_id_m = 5'd0; hz.reg_write_m = 0;
        hz.write_reg_e = 5'd9; hz.reg_write_e = 1;
        #1;
        check("br_e_stall", hz.stall_f, 1);
        clr();
        step();

        // Syscall waits on $v0 writer
        hz.syscall_d = 1; hz.write_reg_e = 5'd2; hz.reg_write_e = 1;
        #1;
        check("sys_stall", hz.stall_f, 1);
        hz.reg_write_e = 0;
        #1;
        check("sys_nostall", hz.stall_f, 0);
        hz.rd_id_w = 5'd4; hz.reg_write_w = 1;
        #1;
        check("sys_w_a0", hz.stall_f, 1);
        clr();
        step();

        // Watchdog: 64 stalled edges saturate the count, flag rises on the next edge
        set_lw_hazard();
        for (int i = 0; i < 64; i++) step();
        check("wd_not_yet", hz.stall_timeout, 0);
        clr();
        step();
        check("wd_set", hz.stall_timeout, 1);
        step();
        step();
        check("wd_sticky", hz.stall_timeout, 1);

        // Async reset mid-divide
        hz.div_op_d = 1;
        step();
        clr();
        step();
        check("pre_rst_busy", hz.hilo_busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", hz.hilo_busy, 0);
        check("arst_timeout", hz.stall_timeout, 0);
        check("arst_stall", hz.stall_f, 0);
        #3;
        reset = 1'b0;
        step();
        check("post_rst_busy", hz.hilo_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout got=hang want=finish");
        $fatal(1, "bench timeout");
    end
endmodule
